// File: rtl/edge_det_if.sv
// Signal bundle for edge_det: master drives inputs/controls, slave (edge_det) drives status.
interface edge_det_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) ();
    logic [WIDTH-1:0]   in;
    logic [2*WIDTH-1:0] mode;
    logic [WIDTH-1:0]   clr;
    logic               cnt_clr;
    logic [WIDTH-1:0]   level;
    logic [WIDTH-1:0]   pulse;
    logic [WIDTH-1:0]   sticky;
    logic               any_event;
    logic [CNT_W-1:0]   evt_cnt;

    modport master (
        output in, mode, clr, cnt_clr,
        input  level, pulse, sticky, any_event, evt_cnt
    );

    modport slave (
        input  in, mode, clr, cnt_clr,
        output level, pulse, sticky, any_event, evt_cnt
    );
endinterface

// File: rtl/edge_det.sv
// Multi-channel synchronising edge detector with sticky flags and a saturating event counter.
// Optional debounce filter is compiled in when EDGE_DET_DEBOUNCE_EN is defined.
module edge_det #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned CNT_W       = 8
) (
    input logic      clk,
    input logic      rst_n,
    edge_det_if.slave bus
);

    if (WIDTH < 1 || SYNC_STAGES < 1 || DEBOUNCE < 1 || CNT_W < 1) begin : g_bad_param
        $error("edge_det: WIDTH, SYNC_STAGES, DEBOUNCE and CNT_W must all be >= 1");
    end

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] level_q, level_next;
    logic [WIDTH-1:0] pulse_q, pulse_next;
    logic [WIDTH-1:0] sticky_q, sticky_next;
    logic [CNT_W-1:0] cnt_q, cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= bus.in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DET_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE) + 1;

    logic [WIDTH-1:0][DB_W-1:0] db_q, db_next;

    always_comb begin
        level_next = level_q;
        db_next    = db_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (s[i] == level_q[i]) begin
                db_next[i] = '0;
            end else if (db_q[i] == DB_W'(DEBOUNCE - 1)) begin
                level_next[i] = s[i];
                db_next[i]    = '0;
            end else begin
                db_next[i] = db_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q <= '0;
        end else begin
            db_q <= db_next;
        end
    end
`else
    always_comb begin
        level_next = s;
    end
`endif

    // Edges compare the value being accepted this cycle with the currently held level.
    always_comb begin
        pulse_next = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pulse_next[i] = (level_next[i] & ~level_q[i] & bus.mode[2*i])
                          | (~level_next[i] & level_q[i] & bus.mode[2*i+1]);
        end
    end

    // A new event beats a same-cycle clear so no event is ever lost.
    always_comb begin
        sticky_next = pulse_next | (sticky_q & ~bus.clr);
    end

    always_comb begin
        cnt_next = cnt_q;
        if (bus.cnt_clr) begin
            cnt_next = '0;
        end else if (|pulse_next && !(&cnt_q)) begin
            cnt_next = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q  <= '0;
            pulse_q  <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            level_q  <= level_next;
            pulse_q  <= pulse_next;
            sticky_q <= sticky_next;
            cnt_q    <= cnt_next;
        end
    end

    assign bus.level     = level_q;
    assign bus.pulse     = pulse_q;
    assign bus.sticky    = sticky_q;
    assign bus.any_event = |pulse_q;
    assign bus.evt_cnt   = cnt_q;

endmodule

// File: tb/tb_edge_det.sv
// Scoreboard bench for edge_det: stimulus queues expected pulses, a monitor pops them on any_event.
module tb_edge_det;

`ifdef EDGE_DET_DEBOUNCE_EN
    localparam int unsigned LAT = 2 + 4;
`else
    localparam int unsigned LAT = 2 + 1;
`endif

    typedef struct {
        int unsigned cyc;
        logic [7:0]  pulse;
        logic [7:0]  cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int unsigned cyc;
    int unsigned total;
    int unsigned bad;
    exp_t        q[$];
    exp_t        e;
    logic [7:0]  exp_cnt;

    edge_det_if #(.WIDTH(8), .CNT_W(8)) bus ();
    edge_det_if #(.WIDTH(8), .CNT_W(2)) bus_s ();

    assign bus_s.in      = bus.in;
    assign bus_s.mode    = bus.mode;
    assign bus_s.clr     = bus.clr;
    assign bus_s.cnt_clr = bus.cnt_clr;

    edge_det #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(4), .CNT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    edge_det #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(4), .CNT_W(2)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expect an event LAT edges after the current drive point.
    task automatic push(input logic [7:0] p);
        exp_t x;
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        x.cyc   = cyc + LAT;
        x.pulse = p;
        x.cnt   = exp_cnt;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.any_event === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {24'd0, bus.pulse}, 32'd0);
            end else begin
                e = q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_vec", {24'd0, bus.pulse}, {24'd0, e.pulse});
                check("evt_cnt", {24'd0, bus.evt_cnt}, {24'd0, e.cnt});
            end
        end
    end

    initial begin
        total   = 0;
        bad     = 0;
        exp_cnt = 8'd0;
        rst_n        = 1'b0;
        bus.in       = '0;
        bus.mode     = 16'h5555;
        bus.clr      = '0;
        bus.cnt_clr  = 1'b0;
        tick(3);
        check("rst_level", {24'd0, bus.level}, 32'd0);
        check("rst_pulse", {24'd0, bus.pulse}, 32'd0);
        check("rst_sticky", {24'd0, bus.sticky}, 32'd0);
        check("rst_cnt", {24'd0, bus.evt_cnt}, 32'd0);
        check("rst_any", {31'd0, bus.any_event}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // rise on ch0 pulses, fall does not
        bus.in[0] = 1'b1; push(8'h01);
        tick(10);
        check("ch0_sticky", {24'd0, bus.sticky}, 32'h01);
        check("ch0_level_hi", {31'd0, bus.level[0]}, 32'd1);
        check("sat_cnt_1", {30'd0, bus_s.evt_cnt}, 32'd1);
        bus.in[0] = 1'b0;
        tick(10);
        check("ch0_level_lo", {31'd0, bus.level[0]}, 32'd0);

        // ch3 both edges
        bus.mode = 16'h55D5;
        bus.in[3] = 1'b1; push(8'h08);
        tick(10);
        check("sat_cnt_2", {30'd0, bus_s.evt_cnt}, 32'd2);
        bus.in[3] = 1'b0; push(8'h08);
        tick(10);
        check("sat_cnt_3", {30'd0, bus_s.evt_cnt}, 32'd3);

        // ch3 fall only
        bus.mode = 16'h5595;
        bus.in[3] = 1'b1;
        tick(10);
        bus.in[3] = 1'b0; push(8'h08);
        tick(10);
        check("sat_cnt_sat_a", {30'd0, bus_s.evt_cnt}, 32'd3);
        check("ch3_sticky", {31'd0, bus.sticky[3]}, 32'd1);

        // ch3 off: level tracks, no pulse
        bus.mode = 16'h5515;
        bus.in[3] = 1'b1;
        tick(10);
        check("ch3_off_level_hi", {31'd0, bus.level[3]}, 32'd1);
        bus.in[3] = 1'b0;
        tick(10);
        check("ch3_off_level_lo", {31'd0, bus.level[3]}, 32'd0);
        bus.mode = 16'h5555;

        // clr[2] concurrent with pulse[2], then alone
        bus.in[2] = 1'b1; push(8'h04);
        tick(LAT - 1);
        bus.clr = 8'h04;
        tick(1);
        bus.clr = 8'h00;
        check("clr_vs_set", {31'd0, bus.sticky[2]}, 32'd1);
        check("sat_cnt_sat_b", {30'd0, bus_s.evt_cnt}, 32'd3);
        tick(3);
        bus.clr = 8'h04;
        tick(1);
        bus.clr = 8'h00;
        check("clr_alone", {31'd0, bus.sticky[2]}, 32'd0);
        check("clr_mask", {24'd0, bus.sticky}, 32'h09);
        bus.in[2] = 1'b0;
        tick(10);

        // cnt_clr concurrent with an event discards the increment
        bus.in[1] = 1'b1; push(8'h02);
        exp_cnt = 8'd0;
        q[q.size()-1].cnt = 8'd0;
        tick(LAT - 1);
        bus.cnt_clr = 1'b1;
        tick(1);
        bus.cnt_clr = 1'b0;
        check("cntclr_sat", {30'd0, bus_s.evt_cnt}, 32'd0);
        tick(9);
        bus.in[4] = 1'b1; push(8'h10);
        tick(10);
        check("cnt_resume_sat", {30'd0, bus_s.evt_cnt}, 32'd1);

`ifdef EDGE_DET_DEBOUNCE_EN
        // 3-cycle glitch rejected, 4-cycle pulse accepted
        bus.in[5] = 1'b1;
        tick(3);
        bus.in[5] = 1'b0;
        tick(10);
        check("glitch_level", {31'd0, bus.level[5]}, 32'd0);
        bus.in[5] = 1'b1; push(8'h20);
        tick(4);
        bus.in[5] = 1'b0;
        tick(2);
        check("db_level_hi", {31'd0, bus.level[5]}, 32'd1);
        tick(10);
        check("db_level_lo", {31'd0, bus.level[5]}, 32'd0);
`endif

        // reset mid-qualification, then all-ones held through release
        bus.in = 8'hFF;
        tick(LAT - 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_level", {24'd0, bus.level}, 32'd0);
        check("async_rst_sticky", {24'd0, bus.sticky}, 32'd0);
        check("async_rst_cnt", {24'd0, bus.evt_cnt}, 32'd0);
        exp_cnt = 8'd0;
        tick(3);
        rst_n = 1'b1;
        push(8'hFF);
        tick(12);
        check("post_rst_sticky", {24'd0, bus.sticky}, 32'hFF);
        check("post_rst_level", {24'd0, bus.level}, 32'hFF);
        check("post_rst_sat", {30'd0, bus_s.evt_cnt}, 32'd1);

        check("drain", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
